lcd_mole_painter: RTL and testbench

Pixel source for the whack-a-mole screen. It sits directly upstream of the RGB LCD timing driver: it takes the driver's per-pixel coordinates and panel size and returns the 24-bit colour for that pixel one clock later. It draws a grid of holes, shows a raised mole in each hole flagged by game logic, and optionally flashes a hole after a hit. Mole state is sampled once per frame so a frame never shows a half-updated (torn) grid.

---
 rtl/lcd_pkg.sv | 18 +
 rtl/lcd_mole_painter_if.sv | 28 ++
 rtl/mole_flash_ctr.sv | 34 +++
 rtl/lcd_mole_painter.sv | 123 ++++++++++++
 tb/tb_lcd_mole_painter.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD pixel painter.
// Holds the coordinate type, the palette and the in-cell region geometry.
package lcd_pkg;

  typedef logic [10:0] coord_t;

  localparam logic [23:0] BG_COLOR   = 24'h2E7D32;
  localparam logic [23:0] HOLE_COLOR = 24'h3E2723;
  localparam logic [23:0] MOLE_COLOR = 24'h8D6E63;
  localparam logic [23:0] HIT_COLOR  = 24'hFFEB3B;

  // Horizontal insets from the cell edge, and heights measured up from the cell bottom.
  localparam int HOLE_INSET = 16;
  localparam int MOLE_INSET = 32;
  localparam int HOLE_H     = 20;
  localparam int MOLE_H     = 40;

endpackage

// File: rtl/lcd_mole_painter_if.sv
// Pixel request / colour response bus between the LCD timing driver and the painter.
// Game-logic mole and hit vectors travel on the same bundle.
interface lcd_mole_painter_if
  import lcd_pkg::*;
#(
  parameter int N = 9
);

  coord_t      pixel_xpos;
  coord_t      pixel_ypos;
  coord_t      h_disp;
  coord_t      v_disp;
  logic [N-1:0] mole_up;
  logic [N-1:0] hit_pulse;
  logic [23:0] pixel_data;
  logic        frame_start;

  modport master (
    output pixel_xpos, pixel_ypos, h_disp, v_disp, mole_up, hit_pulse,
    input  pixel_data, frame_start
  );

  modport slave (
    input  pixel_xpos, pixel_ypos, h_disp, v_disp, mole_up, hit_pulse,
    output pixel_data, frame_start
  );

endinterface

// File: rtl/mole_flash_ctr.sv
// Per-hole hit flash timer: a sticky pending bit captures hits between
// frames, and a frame-rate down-counter keeps the hole flashing.
module mole_flash_ctr #(
  parameter int FLASH_FRAMES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic hit,
  input  logic frame_start,
  output logic flashing
);

  logic       pending;
  logic [7:0] cnt;

  // Hits landing on the frame_start cycle itself load on that same frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      cnt     <= 8'd0;
    end else if (frame_start) begin
      pending <= 1'b0;
      if (pending || hit)
        cnt <= 8'(FLASH_FRAMES);
      else if (cnt != 8'd0)
        cnt <= cnt - 8'd1;
    end else if (hit) begin
      pending <= 1'b1;
    end
  end

  assign flashing = (cnt != 8'd0);

endmodule

// File: rtl/lcd_mole_painter.sv
// Whack-a-mole pixel source: decodes the driver's pixel coordinate into a
// grid cell and region, returns the colour one clock later.
// Optional hit flashing is built when MOLE_PAINTER_FLASH_EN is defined.
module lcd_mole_painter
  import lcd_pkg::*;
#(
  parameter int GRID_COLS    = 3,
  parameter int GRID_ROWS    = 3,
  parameter int CELL_W       = 160,
  parameter int CELL_H       = 90,
  parameter int FLASH_FRAMES = 8
) (
  input  logic              clk,
  input  logic              rst,
  lcd_mole_painter_if.slave bus
);

  localparam int N      = GRID_COLS * GRID_ROWS;
  localparam int GRID_W = GRID_COLS * CELL_W;
  localparam int GRID_H = GRID_ROWS * CELL_H;

  coord_t       x0, y0, ly, cx, cy, ox, oy, last_row;
  int           col, row;
  logic         valid, in_grid, fs_det, in_hole, in_mole, mole_sel, flash_sel;
  logic [23:0]  color_d;
  logic [N-1:0] mole_q;
  logic [N-1:0] flashing;

  // Grid origin, cell decode by comparator chain, region test and colour priority.
  always_comb begin
    valid   = (bus.pixel_ypos != '0);
    ly      = valid ? (bus.pixel_ypos - 11'd1) : '0;
    x0      = (bus.h_disp >= 11'(GRID_W)) ? ((bus.h_disp - 11'(GRID_W)) >> 1) : '0;
    y0      = (bus.v_disp >= 11'(GRID_H)) ? ((bus.v_disp - 11'(GRID_H)) >> 1) : '0;
    cx      = (bus.pixel_xpos >= x0) ? (bus.pixel_xpos - x0) : '0;
    cy      = (ly >= y0) ? (ly - y0) : '0;
    in_grid = valid && (bus.pixel_xpos >= x0) && (ly >= y0) &&
              (cx < 11'(GRID_W)) && (cy < 11'(GRID_H));

    col = 0;
    ox  = cx;
    for (int c = 1; c < GRID_COLS; c++) begin
      if (cx >= 11'(c * CELL_W)) begin
        col = c;
        ox  = cx - 11'(c * CELL_W);
      end
    end
    row = 0;
    oy  = cy;
    for (int r = 1; r < GRID_ROWS; r++) begin
      if (cy >= 11'(r * CELL_H)) begin
        row = r;
        oy  = cy - 11'(r * CELL_H);
      end
    end

    mole_sel  = 1'b0;
    flash_sel = 1'b0;
    for (int r = 0; r < GRID_ROWS; r++) begin
      for (int c = 0; c < GRID_COLS; c++) begin
        if (r == row && c == col) begin
          mole_sel  = mole_q[r*GRID_COLS + c];
          flash_sel = flashing[r*GRID_COLS + c];
        end
      end
    end

    in_hole = (oy >= 11'(CELL_H - HOLE_H)) && (oy < 11'(CELL_H)) &&
              (ox >= 11'(HOLE_INSET)) && (ox < 11'(CELL_W - HOLE_INSET));
    in_mole = (oy >= 11'(CELL_H - HOLE_H - MOLE_H)) && (oy < 11'(CELL_H - HOLE_H)) &&
              (ox >= 11'(MOLE_INSET)) && (ox < 11'(CELL_W - MOLE_INSET));

    color_d = BG_COLOR;
    if (in_grid) begin
      if (flash_sel && in_mole)
        color_d = HIT_COLOR;
      else if (mole_sel && in_mole)
        color_d = MOLE_COLOR;
      else if (in_hole)
        color_d = HOLE_COLOR;
    end
  end

  // A frame begins on line 1 unless the previous requested line was also line 1.
  assign fs_det = (bus.pixel_ypos == 11'd1) && (last_row != 11'd1);

  // Output registers, frame tracking and once-per-frame mole snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pixel_data  <= 24'd0;
      bus.frame_start <= 1'b0;
      last_row        <= '0;
      mole_q          <= '0;
    end else begin
      bus.pixel_data  <= color_d;
      bus.frame_start <= fs_det;
      if (valid)
        last_row <= bus.pixel_ypos;
      if (fs_det)
        mole_q <= bus.mole_up;
    end
  end

`ifdef MOLE_PAINTER_FLASH_EN
  for (genvar i = 0; i < N; i++) begin : g_flash
    mole_flash_ctr #(
      .FLASH_FRAMES(FLASH_FRAMES)
    ) u_flash (
      .clk        (clk),
      .rst        (rst),
      .hit        (bus.hit_pulse[i]),
      .frame_start(fs_det),
      .flashing   (flashing[i])
    );
  end
`else
  // No flash hardware: the hit vector and frame count are deliberately dropped.
  logic unused_ok;
  assign unused_ok = ^{bus.hit_pulse, 8'(FLASH_FRAMES)};
  assign flashing  = '0;
`endif

endmodule

// File: tb/tb_lcd_mole_painter.sv
module tb_lcd_mole_painter;
  import lcd_pkg::*;

`ifdef MOLE_PAINTER_FLASH_EN
  localparam logic [23:0] HIT_EXP = HIT_COLOR;
`else
  localparam logic [23:0] HIT_EXP = BG_COLOR;
`endif

  typedef struct {
    int          x;
    int          y;
    logic [23:0] exp;
  } vec_t;

  localparam int NV = 24;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  lcd_mole_painter_if #(.N(9)) bus ();

  lcd_mole_painter #(
    .GRID_COLS   (3),
    .GRID_ROWS   (3),
    .CELL_W      (160),
    .CELL_H      (90),
    .FLASH_FRAMES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic req(input int x, input int y, input logic [8:0] hit = 9'h000);
    @(negedge clk);
    bus.pixel_xpos = 11'(x);
    bus.pixel_ypos = 11'(y);
    bus.hit_pulse  = hit;
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input string name, input int x, input int y, input logic [23:0] exp);
    req(x, y);
    check(name, bus.pixel_data, exp);
  endtask

  task automatic new_frame(input logic [8:0] hit = 9'h000);
    req(0, 1, hit);
    check("frame_start", {23'd0, bus.frame_start}, 24'd1);
    req(0, 2);
  endtask

  initial begin
    vecs = '{
      '{80, 52, MOLE_COLOR}, '{80, 82, HOLE_COLOR}, '{10, 52, BG_COLOR},
      '{20, 82, HOLE_COLOR}, '{15, 82, BG_COLOR},   '{31, 52, BG_COLOR},
      '{32, 52, MOLE_COLOR}, '{127, 52, MOLE_COLOR}, '{128, 52, BG_COLOR},
      '{80, 31, BG_COLOR},   '{80, 32, MOLE_COLOR}, '{80, 71, MOLE_COLOR},
      '{80, 72, HOLE_COLOR}, '{80, 91, HOLE_COLOR}, '{80, 92, BG_COLOR},
      '{240, 142, MOLE_COLOR}, '{400, 52, BG_COLOR}, '{400, 82, HOLE_COLOR},
      '{240, 271, HOLE_COLOR}, '{240, 272, BG_COLOR}, '{143, 82, HOLE_COLOR},
      '{144, 82, BG_COLOR},  '{100, 0, BG_COLOR},   '{479, 82, BG_COLOR}
    };

    rst            = 1'b1;
    bus.pixel_xpos = '0;
    bus.pixel_ypos = '0;
    bus.h_disp     = 11'd480;
    bus.v_disp     = 11'd272;
    bus.mole_up    = '0;
    bus.hit_pulse  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel", bus.pixel_data, 24'd0);
    check("rst_fs", {23'd0, bus.frame_start}, 24'd0);
    @(negedge clk);
    rst = 1'b0;

    // First request after reset opens a frame; line 0 lies above the grid.
    req(0, 1);
    check("first_fs", {23'd0, bus.frame_start}, 24'd1);
    check("first_pixel", bus.pixel_data, BG_COLOR);
    req(0, 2);
    check("second_fs", {23'd0, bus.frame_start}, 24'd0);

    // Static decode with holes 0 and 4 raised.
    bus.mole_up = 9'h011;
    new_frame();
    for (int i = 0; i < NV; i++)
      pix($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].exp);

    // Mole change mid-frame stays hidden until the next frame.
    bus.mole_up = 9'h000;
    pix("midframe_hold", 80, 52, MOLE_COLOR);
    new_frame();
    pix("after_frame", 80, 52, BG_COLOR);

    // Hit between frames: flashes for 8 frames starting at the next frame.
    bus.mole_up = 9'h001;
    req(0, 5, 9'h010);
    pix("hit_before_fs", 240, 142, BG_COLOR);
    for (int k = 1; k <= 9; k++) begin
      new_frame();
      pix($sformatf("flash_f%0d", k), 240, 142, (k <= 8) ? HIT_EXP : BG_COLOR);
    end
    pix("flash_other_hole", 80, 52, MOLE_COLOR);

    // Hit coincident with frame_start loads on that frame, then a re-hit reloads.
    new_frame(9'h010);
    pix("coinc_f0", 240, 142, HIT_EXP);
    for (int k = 1; k <= 3; k++) begin
      new_frame();
      pix($sformatf("coinc_f%0d", k), 240, 142, HIT_EXP);
    end
    req(0, 7, 9'h010);
    for (int k = 1; k <= 9; k++) begin
      new_frame();
      pix($sformatf("reload_f%0d", k), 240, 142, (k <= 8) ? HIT_EXP : BG_COLOR);
    end

    // Reset mid-line: outputs clear at once, moles stay down until a new frame.
    pix("pre_reset", 80, 52, MOLE_COLOR);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_pixel", bus.pixel_data, 24'd0);
    check("midreset_fs", {23'd0, bus.frame_start}, 24'd0);
    @(negedge clk);
    rst = 1'b0;
    pix("post_reset_nomole", 80, 52, BG_COLOR);
    check("post_reset_fs", {23'd0, bus.frame_start}, 24'd0);
    new_frame();
    pix("post_reset_frame", 80, 52, MOLE_COLOR);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
